// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI MOSI burst serialiser.
// Widths depend on instance parameters, so they are exposed as constant functions.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bit counter must index the wider of the address and data words.
  function automatic int bit_cnt_w(input int addr_w, input int data_w);
    return (max_w(addr_w, data_w) > 1) ? $clog2(max_w(addr_w, data_w)) : 1;
  endfunction

  function automatic int div_cnt_w(input int half_div);
    return (half_div > 1) ? $clog2(half_div) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Small synchronous FIFO with combinational head read; push is refused when full
// even if a pop happens on the same edge.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/spi_mosi_burst.sv
// MOSI serialiser: one address word followed by a burst of FIFO data words,
// with its own mode-0 serial clock and abort on early chip-select release.
module spi_mosi_burst
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 0,
  parameter int HALF_DIV   = 1
) (
  input  logic                              spi_clk,
  input  logic                              n_reset,
  input  logic                              spi_cs,
  input  logic [ADDR_W-1:0]                 add_byte,
  input  logic [DATA_W-1:0]                 spi_mosi_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              control_clk,
  output logic                              spi_mosi_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              frame_done,
  output logic                              abort
);

  localparam int SH_W = max_w(ADDR_W, DATA_W);
  localparam int BC_W = bit_cnt_w(ADDR_W, DATA_W);
  localparam int DC_W = div_cnt_w(HALF_DIV);
  localparam logic [DC_W-1:0] DIV_LAST = DC_W'(HALF_DIV - 1);

  state_t            state_reg;
  logic [SH_W-1:0]   shift_reg;
  logic [BC_W-1:0]   bit_cnt_reg;
  logic [DC_W-1:0]   div_cnt_reg;
  logic              ctl_reg, mosi_reg, busy_reg, done_reg, abort_reg, armed_reg;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [BC_W-1:0]   last_bit;
  logic [SH_W-1:0]   addr_word, data_word;
  logic              shifting, bit_end, word_end, pop;

  // Words are justified so the first bit to send sits at the shift-out end.
  function automatic logic [SH_W-1:0] justify(input logic [SH_W-1:0] w, input int width);
    logic [SH_W-1:0] r;
    r = w;
    if (LSB_FIRST == 0) r = w << (SH_W - width);
    return r;
  endfunction

  function automatic logic head_bit(input logic [SH_W-1:0] r);
    return (LSB_FIRST != 0) ? r[0] : r[SH_W-1];
  endfunction

  function automatic logic [SH_W-1:0] advance(input logic [SH_W-1:0] r);
    return (LSB_FIRST != 0) ? (r >> 1) : (r << 1);
  endfunction

  assign addr_word = justify(SH_W'(add_byte), ADDR_W);
  assign data_word = justify(SH_W'(fifo_head), DATA_W);
  assign last_bit  = (state_reg == ADDR) ? BC_W'(ADDR_W - 1) : BC_W'(DATA_W - 1);
  assign shifting  = ((state_reg == ADDR) || (state_reg == DATA)) && !spi_cs;
  assign bit_end   = shifting && ctl_reg && (div_cnt_reg == DIV_LAST);
  assign word_end  = bit_end && (bit_cnt_reg == last_bit);
  assign pop       = word_end && !fifo_empty;

  spi_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (spi_clk),
    .n_reset (n_reset),
    .push    (in_valid),
    .wdata   (spi_mosi_in),
    .pop     (pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge spi_clk) begin
    if (!n_reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      ctl_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      abort_reg   <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // After a frame, CS must be seen high once before a new frame may start.
          if (spi_cs) begin
            armed_reg <= 1'b1;
          end else if (armed_reg) begin
            state_reg   <= ADDR;
            armed_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            shift_reg   <= advance(addr_word);
            mosi_reg    <= head_bit(addr_word);
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            ctl_reg     <= 1'b0;
          end
        end
        ADDR, DATA: begin
          if (spi_cs) begin
            state_reg <= IDLE;
            armed_reg <= 1'b1;
            busy_reg  <= 1'b0;
            ctl_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            abort_reg <= 1'b1;
          end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (!ctl_reg) begin
              ctl_reg <= 1'b1;
            end else begin
              ctl_reg <= 1'b0;
              if (pop) begin
                state_reg   <= DATA;
                shift_reg   <= advance(data_word);
                mosi_reg    <= head_bit(data_word);
                bit_cnt_reg <= '0;
              end else if (word_end) begin
                state_reg <= DONE;
                mosi_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
                mosi_reg    <= head_bit(shift_reg);
                shift_reg   <= advance(shift_reg);
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DC_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready     = !fifo_full;
  assign control_clk  = ctl_reg;
  assign spi_mosi_out = mosi_reg;
  assign busy         = busy_reg;
  assign frame_done   = done_reg;
  assign abort        = abort_reg;

endmodule

// File: tb/tb_spi_mosi_burst.sv
// Bench for spi_mosi_burst: three instances (MSB-first, LSB-first, HALF_DIV=3) share stimulus
// and are checked against a word-level reference of the serial bit stream.
module tb_spi_mosi_burst;

  localparam int NI = 3;

  logic       spi_clk = 1'b0;
  logic       n_reset, spi_cs, in_valid;
  logic [7:0] add_byte, spi_mosi_in;
  logic       in_ready [NI];
  logic       ctl [NI];
  logic       mosi [NI];
  logic       busy [NI];
  logic       fdone [NI];
  logic       abrt [NI];
  logic [2:0] level [NI];

  always #5 spi_clk = ~spi_clk;

  spi_mosi_burst #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4), .LSB_FIRST(0), .HALF_DIV(1)) u_msb (
    .spi_clk(spi_clk), .n_reset(n_reset), .spi_cs(spi_cs), .add_byte(add_byte),
    .spi_mosi_in(spi_mosi_in), .in_valid(in_valid), .in_ready(in_ready[0]),
    .control_clk(ctl[0]), .spi_mosi_out(mosi[0]), .busy(busy[0]), .fifo_level(level[0]),
    .frame_done(fdone[0]), .abort(abrt[0]));

  spi_mosi_burst #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1), .HALF_DIV(1)) u_lsb (
    .spi_clk(spi_clk), .n_reset(n_reset), .spi_cs(spi_cs), .add_byte(add_byte),
    .spi_mosi_in(spi_mosi_in), .in_valid(in_valid), .in_ready(in_ready[1]),
    .control_clk(ctl[1]), .spi_mosi_out(mosi[1]), .busy(busy[1]), .fifo_level(level[1]),
    .frame_done(fdone[1]), .abort(abrt[1]));

  spi_mosi_burst #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4), .LSB_FIRST(0), .HALF_DIV(3)) u_div (
    .spi_clk(spi_clk), .n_reset(n_reset), .spi_cs(spi_cs), .add_byte(add_byte),
    .spi_mosi_in(spi_mosi_in), .in_valid(in_valid), .in_ready(in_ready[2]),
    .control_clk(ctl[2]), .spi_mosi_out(mosi[2]), .busy(busy[2]), .fifo_level(level[2]),
    .frame_done(fdone[2]), .abort(abrt[2]));

  // Monitor: bits captured at each control_clk rise, pulse counts, idle-output violations.
  logic cap_bits [NI][8192];
  int   cap_n [NI];
  int   fdone_n [NI];
  int   abort_n [NI];
  int   idle_viol [NI];
  logic ctl_prev [NI];
  logic busy_prev [NI];
  int   run_len;
  int   phase_bad;

  always @(negedge spi_clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ctl[i] === 1'b1 && ctl_prev[i] === 1'b0) begin
        cap_bits[i][cap_n[i]] <= mosi[i];
        cap_n[i] <= cap_n[i] + 1;
      end
      if (fdone[i] === 1'b1) fdone_n[i] <= fdone_n[i] + 1;
      if (abrt[i] === 1'b1)  abort_n[i] <= abort_n[i] + 1;
      if (n_reset === 1'b1 && busy[i] === 1'b0 && (mosi[i] !== 1'b0 || ctl[i] !== 1'b0))
        idle_viol[i] <= idle_viol[i] + 1;
      ctl_prev[i]  <= ctl[i];
      busy_prev[i] <= busy[i];
    end
    if (busy[2] === 1'b1) begin
      if (ctl[2] !== ctl_prev[2]) begin
        if (busy_prev[2] === 1'b1 && run_len != 3) phase_bad <= phase_bad + 1;
        run_len <= 1;
      end else begin
        run_len <= run_len + 1;
      end
    end else begin
      run_len <= 0;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] words [8];

  task automatic tick(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic apply_reset();
    n_reset = 1'b0; spi_cs = 1'b1; in_valid = 1'b0;
    tick(2);
    n_reset = 1'b1;
    tick(2);
  endtask

  task automatic push_words(input int first, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      spi_mosi_in = words[first + k];
      in_valid = 1'b1;
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(busy[0] === 1'b0 && busy[1] === 1'b0 && busy[2] === 1'b0) && t < 4000) begin
      tick(1);
      t++;
    end
    checks++;
    if (t >= 4000) begin
      errors++;
      $display("FAIL %s wait_idle: busy=%b%b%b still set, required 000 within 4000 cycles",
               name, busy[0], busy[1], busy[2]);
    end
  endtask

  // Reference: bit k of the frame is bit (k%8) of word k/8, counted from the LSB or the MSB.
  function automatic logic ref_bit(input int i, input logic [7:0] addr, input int first, input int k);
    logic [7:0] w;
    int pos;
    w   = (k / 8 == 0) ? addr : words[first + k / 8 - 1];
    pos = k % 8;
    return (i == 1) ? w[pos] : w[7 - pos];
  endfunction

  task automatic check_frame(input int i, input int cbase, input int fbase, input int abase,
                             input logic [7:0] addr, input int first, input int cnt,
                             input string name);
    int exp_len = 8 * (1 + cnt);
    int bad = 0;
    int bad_k = -1;
    checks++;
    if (cap_n[i] - cbase !== exp_len) begin
      errors++;
      $display("FAIL %s inst%0d rise_count: got %0d, required %0d", name, i, cap_n[i] - cbase, exp_len);
    end
    for (int k = 0; k < exp_len; k++) begin
      if (cap_bits[i][cbase + k] !== ref_bit(i, addr, first, k)) begin
        bad++;
        if (bad_k < 0) bad_k = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s inst%0d mosi_bits: %0d wrong, first at bit %0d got %b required %b",
               name, i, bad, bad_k, cap_bits[i][cbase + bad_k], ref_bit(i, addr, first, bad_k));
    end
    checks++;
    if (fdone_n[i] - fbase !== 1 || abort_n[i] - abase !== 0) begin
      errors++;
      $display("FAIL %s inst%0d pulses: frame_done %0d abort %0d, required 1 and 0",
               name, i, fdone_n[i] - fbase, abort_n[i] - abase);
    end
    checks++;
    if (level[i] !== 3'd0 || busy[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s inst%0d end_state: level %0d busy %b, required 0 and 0", name, i, level[i], busy[i]);
    end
  endtask

  // Runs a frame with the given address; per-instance first word and count of data words sent.
  task automatic run_frame(input logic [7:0] addr, input int f0, input int c0, input int f2, input int c2,
                           input string name);
    int cb [NI];
    int fb [NI];
    int ab [NI];
    for (int i = 0; i < NI; i++) begin
      cb[i] = cap_n[i]; fb[i] = fdone_n[i]; ab[i] = abort_n[i];
    end
    add_byte = addr;
    spi_cs = 1'b0;
    tick(2);
    wait_idle(name);
    tick(1);
    spi_cs = 1'b1;
    tick(2);
    for (int i = 0; i < NI; i++)
      check_frame(i, cb[i], fb[i], ab[i], addr, (i == 2) ? f2 : f0, (i == 2) ? c2 : c0, name);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({ctl[i], mosi[i], busy[i], fdone[i], abrt[i], level[i], in_ready[i]} !== 9'b00000_000_1) begin
        errors++;
        $display("FAIL reset inst%0d: ctl/mosi/busy/done/abort/level/ready = %b%b%b%b%b/%0d/%b, required 00000/0/1",
                 i, ctl[i], mosi[i], busy[i], fdone[i], abrt[i], level[i], in_ready[i]);
      end
    end
  endtask

  task automatic test_basic_burst();
    apply_reset();
    words[0] = 8'd1; words[1] = 8'd2; words[2] = 8'd3;
    push_words(0, 3);
    run_frame(8'd45, 0, 3, 0, 3, "basic_burst");
    $display("basic_burst addr=45 words=1,2,3 done");
  endtask

  task automatic test_lsb_empty();
    apply_reset();
    run_frame(8'b01000111, 0, 0, 0, 0, "addr_only");
    $display("addr_only addr=0x47 no data done");
  endtask

  task automatic test_half_div();
    int pb;
    apply_reset();
    pb = phase_bad;
    words[0] = 8'b01100001;
    push_words(0, 1);
    run_frame(8'($urandom_range(0, 255)), 0, 1, 0, 1, "half_div");
    checks++;
    if (phase_bad - pb != 0) begin
      errors++;
      $display("FAIL half_div phase_len: %0d phases not 3 cycles, required 0", phase_bad - pb);
    end
    $display("half_div word=0x61 done");
  endtask

  task automatic test_random_bursts();
    for (int r = 0; r < 6; r++) begin
      int cnt;
      logic [7:0] a;
      apply_reset();
      cnt = $urandom_range(0, 4);
      a = 8'($urandom_range(0, 255));
      for (int k = 0; k < cnt; k++) words[k] = 8'($urandom_range(0, 255));
      push_words(0, cnt);
      run_frame(a, 0, cnt, 0, cnt, "random_burst");
      $display("random_burst %0d addr=0x%02h words=%0d done", r, a, cnt);
    end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    for (int k = 0; k < 5; k++) words[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 5; k++) begin
      spi_mosi_in = words[k];
      in_valid = 1'b1;
      tick(1);
      if (k == 3) begin
        checks++;
        if (in_ready[0] !== 1'b0 || level[0] !== 3'd4) begin
          errors++;
          $display("FAIL fifo_full after_4th: in_ready %b level %0d, required 0 and 4", in_ready[0], level[0]);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (level[1] !== 3'd4 || in_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full after_5th: level %0d in_ready %b, required 4 and 0", level[1], in_ready[1]);
    end
    run_frame(8'($urandom_range(0, 255)), 0, 4, 0, 4, "fifo_full_drain");
    $display("fifo_full 5 pushes, 4 stored and sent");
  endtask

  task automatic test_abort_resume();
    int cb, fb [NI], ab [NI], t;
    apply_reset();
    for (int k = 0; k < 4; k++) words[k] = 8'($urandom_range(0, 255));
    push_words(0, 4);
    for (int i = 0; i < NI; i++) begin fb[i] = fdone_n[i]; ab[i] = abort_n[i]; end
    cb = cap_n[0];
    add_byte = 8'($urandom_range(0, 255));
    spi_cs = 1'b0;
    t = 0;
    while (cap_n[0] - cb < 20 && t < 500) begin tick(1); t++; end
    spi_cs = 1'b1;
    tick(3);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (abort_n[i] - ab[i] !== 1 || fdone_n[i] - fb[i] !== 0 || busy[i] !== 1'b0 || mosi[i] !== 1'b0
          || level[i] !== ((i == 2) ? 3'd4 : 3'd2)) begin
        errors++;
        $display("FAIL abort inst%0d: abort %0d done %0d busy %b mosi %b level %0d, required 1 0 0 0 %0d",
                 i, abort_n[i] - ab[i], fdone_n[i] - fb[i], busy[i], mosi[i], level[i], (i == 2) ? 4 : 2);
      end
    end
    $display("abort during word 2, retained FIFO words");
    run_frame(8'($urandom_range(0, 255)), 2, 2, 0, 4, "resume");
    $display("resume after abort done");
  endtask

  task automatic test_reset_mid();
    int fb;
    apply_reset();
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom_range(0, 255));
    push_words(0, 3);
    fb = fdone_n[0];
    spi_cs = 1'b0;
    tick(40);
    n_reset = 1'b0;
    spi_cs = 1'b1;
    tick(2);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({ctl[i], mosi[i], busy[i], level[i]} !== 6'b000_000) begin
        errors++;
        $display("FAIL reset_mid inst%0d: ctl %b mosi %b busy %b level %0d, required all 0",
                 i, ctl[i], mosi[i], busy[i], level[i]);
      end
    end
    n_reset = 1'b1;
    tick(5);
    checks++;
    if (busy[0] !== 1'b0 || fdone_n[0] - fb !== 0) begin
      errors++;
      $display("FAIL reset_mid idle_after: busy %b frame_done %0d, required 0 and 0", busy[0], fdone_n[0] - fb);
    end
    $display("reset mid-DATA done");
  endtask

  task automatic test_back_to_back();
    int pushed, t;
    int cb [NI];
    int fb [NI];
    int ab [NI];
    logic [7:0] a;
    apply_reset();
    for (int k = 0; k < 4; k++) words[k] = 8'($urandom_range(0, 255));
    push_words(0, 1);
    for (int i = 0; i < NI; i++) begin cb[i] = cap_n[i]; fb[i] = fdone_n[i]; ab[i] = abort_n[i]; end
    a = 8'($urandom_range(0, 255));
    add_byte = a;
    spi_cs = 1'b0;
    tick(2);
    pushed = 1;
    t = 0;
    // Refill whenever the fast instance drains, so the burst keeps going without a gap.
    while (busy[0] === 1'b1 && t < 2000) begin
      if (level[0] === 3'd0 && pushed < 4) begin
        spi_mosi_in = words[pushed];
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        pushed++;
      end else begin
        tick(1);
      end
      t++;
    end
    wait_idle("back_to_back");
    tick(1);
    spi_cs = 1'b1;
    tick(2);
    for (int i = 0; i < NI; i++)
      check_frame(i, cb[i], fb[i], ab[i], a, 0, 4, "back_to_back");
    $display("back_to_back refilled burst of 4 words done");
  endtask

  initial begin
    n_reset = 1'b0; spi_cs = 1'b1; in_valid = 1'b0; add_byte = '0; spi_mosi_in = '0;
    run_len = 0; phase_bad = 0;
    test_reset();
    test_basic_burst();
    test_lsb_empty();
    test_half_div();
    test_fifo_full();
    test_abort_resume();
    test_reset_mid();
    test_back_to_back();
    test_random_bursts();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (idle_viol[i] != 0) begin
        errors++;
        $display("FAIL idle_outputs inst%0d: %0d cycles with mosi/ctl high while not busy, required 0",
                 i, idle_viol[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
